pipelined_carry_select_adder: RTL and testbench
===============================================

Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined successor to the combinational N-bit carry-select adder.
- Carry-select blocks are grouped into register-separated stages. Each stage resolves its blocks using the carry registered from the previous stage.
- Adds add/subtract mode, signed-overflow flag and a valid/ready handshake with full backpressure.
- Used wherever a wide add/sub must meet timing in the clocked datapath (ALU, accumulators).

Parameters:
- N, 32: operand/sum width in bits. Must be divisible by SIZE.
- SIZE, 4: bits per carry-select block. Each block holds two ripple sums (cin=0 and cin=1) plus a select.
- BPS, 2: carry-select blocks per pipeline stage. BLOCK = N/SIZE must be divisible by BPS.
- Derived STAGES = BLOCK/BPS. This is the number of register stages and equals the latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry in; used only when sub=0.
- sub  input  1  1 = compute a - b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result.
- cout  output  1  carry out. In sub mode, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all stage valid bits = 0;
  - all data/carry registers = 0;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 on the first cycle after deassert.
- Operand preparation at accept:
  - bx = sub ? ~b : b;
  - c0 = sub ? 1 : cin.
- Stage s (0..STAGES-1):
  - Processes blocks s*BPS .. s*BPS+BPS-1 using the carry register from stage s-1 (c0 for stage 0).
  - Within a stage, block carries chain combinationally through the sum/cout muxes, exactly as in the combinational carry-select adder.
  - Result bits for those blocks, still-unprocessed a/bx bits, and already-resolved lower sum bits are registered together with the outgoing carry and a valid bit.
- Final stage output registers:
  - sum;
  - cout = carry out of bit N-1;
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
- Handshake and flow control:
  - Transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - Stage k advances when it holds valid data and stage k+1 is empty or advancing. The last stage advances when out_ready=1.
  - in_ready = !valid[0] || stage 0 advancing. This is combinational from out_ready through the chain; no other comb path from input to output.
  - Bubbles collapse: an empty stage accepts regardless of downstream stall.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accept to out_valid when not stalled.
  - Throughput is 1 result/cycle.
  - Capacity is STAGES results in flight.
- Ordering is strictly FIFO. No result is dropped or duplicated under any stall pattern.
- Output stability while out_valid && !out_ready: sum/cout/ovf stay stable, and out_valid stays 1.
- When out_valid=0, sum/cout/ovf hold their last values (do not care for checking).
- Reset mid-operation clears every in-flight result immediately. No partial result is ever emitted.
- Simultaneous accept and emit in the same cycle while full is allowed: full throughput, in_ready=1.
- With BPS=BLOCK (STAGES=1), the block degenerates to the combinational adder followed by one output register with handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Required: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Add carry wrap (N=32, SIZE=4, BPS=2, STAGES=4): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0. Required 4 cycles later: sum=0x00000000, cout=1, ovf=0.
  - Also a=0x7FFFFFFF, b=1. Required: sum=0x80000000, cout=0, ovf=1.
- Subtract: a=0x80000000, b=1, sub=1. Required: sum=0x7FFFFFFF, cout=1, ovf=1.
  - Also a=0, b=1, sub=1. Required: sum=0xFFFFFFFF, cout=0, ovf=0.
- Backpressure: stream 10 operands (a=i, b=i*3) with out_ready=0 from cycle 2.
  - Required: in_ready drops after exactly 4 accepts.
  - Required: outputs held stable.
  - Then raise out_ready. Required: results 0, 4, 8, ..., 36 arrive in order with no gaps while in_valid stays high.
- Reset mid-stream: accept 3 operands, pulse rst_n low for 1 cycle in the next cycle. Required: out_valid never asserts for those operands.
- Parameter sweep: (N=16, SIZE=4, BPS=4, STAGES=1) and (N=64, SIZE=8, BPS=1, STAGES=8).
  - Stimulus: 10k random a, b, cin, sub with random in_valid/out_ready.
  - Required: every result matches the reference {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), plus the ovf rule.
  - Required: latency = STAGES when unstalled.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_select_adder
//   Parametrised, pipelined N-bit carry-select adder/subtractor with a
//   valid/ready handshake on both sides and full backpressure.
//
//   The N bits are split into BLOCK = N/SIZE carry-select blocks. Every block
//   precomputes its sum for carry-in 0 and for carry-in 1, and the real carry
//   picks one of the two. BPS blocks make up one pipeline stage, so there are
//   STAGES = BLOCK/BPS register stages. Each stage resolves its blocks using
//   the carry registered by the stage before it.
//
//   Ports
//     clk, rst_n           rising-edge clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake (a, b, cin, sub)
//     a, b                 N-bit operands
//     cin                  carry in, ignored when sub=1
//     sub                  1 = compute a - b
//     out_valid/out_ready  result handshake (sum, cout, ovf)
//     sum                  N-bit result
//     cout                 carry out of bit N-1; in sub mode 1 = no borrow
//     ovf                  signed overflow
// -----------------------------------------------------------------------------
module pipelined_carry_select_adder #(
    parameter int N    = 32,
    parameter int SIZE = 4,
    parameter int BPS  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int BLOCK  = N / SIZE;
    localparam int STAGES = BLOCK / BPS;

    // Per-stage state. Each stage carries the whole operand and sum words;
    // bits a stage neither reads nor writes are simply passed along.
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] carry_r;
    logic [STAGES-1:0] carry_s;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] load_s;
    logic [N-1:0]      a_r   [STAGES];
    logic [N-1:0]      a_s   [STAGES];
    logic [N-1:0]      bx_r  [STAGES];
    logic [N-1:0]      bx_s  [STAGES];
    logic [N-1:0]      sum_r [STAGES];
    logic [N-1:0]      sum_s [STAGES];
    logic              ovf_r;
    logic              ovf_s;

    // One carry-select block: both ripple sums, then the carry selects one.
    function automatic logic [SIZE:0] cs_block(input logic [SIZE-1:0] x,
                                               input logic [SIZE-1:0] y,
                                               input logic            c);
        logic [SIZE:0] r0;
        logic [SIZE:0] r1;
        r0 = {1'b0, x} + {1'b0, y};
        r1 = {1'b0, x} + {1'b0, y} + {{SIZE{1'b0}}, 1'b1};
        return c ? r1 : r0;
    endfunction

    // Flow control: walk from the output back to the input. A stage may load
    // when it is empty or when its content moves on this cycle, which is
    // exactly the condition under which the stage in front of it advances.
    always_comb begin
        logic down_ok;
        down_ok = out_ready;
        adv_s   = '0;
        load_s  = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv_s[s]  = valid_r[s] & down_ok;
            load_s[s] = ~valid_r[s] | adv_s[s];
            down_ok   = load_s[s];
        end
    end

    assign in_ready = load_s[0];

    // Datapath: resolve each stage's blocks and compute next register values.
    always_comb begin
        logic [N-1:0]  src_a;
        logic [N-1:0]  src_bx;
        logic [N-1:0]  src_sum;
        logic          carry;
        logic          in_v;
        logic [SIZE:0] blk;
        int            prev;
        int            idx;
        src_a   = '0;
        src_bx  = '0;
        src_sum = '0;
        carry   = 1'b0;
        in_v    = 1'b0;
        blk     = '0;
        prev    = 0;
        idx     = 0;
        valid_s = valid_r;
        carry_s = carry_r;
        a_s     = a_r;
        bx_s    = bx_r;
        sum_s   = sum_r;
        ovf_s   = ovf_r;
        for (int s = 0; s < STAGES; s++) begin
            prev = (s > 0) ? (s - 1) : 0;
            if (s == 0) begin
                // Subtraction is a + ~b + 1, so the inversion and the forced
                // carry are applied once, on entry.
                src_a   = a;
                src_bx  = sub ? ~b : b;
                src_sum = '0;
                carry   = sub ? 1'b1 : cin;
                in_v    = in_valid;
            end else begin
                src_a   = a_r[prev];
                src_bx  = bx_r[prev];
                src_sum = sum_r[prev];
                carry   = carry_r[prev];
                in_v    = valid_r[prev];
            end
            for (int j = 0; j < BPS; j++) begin
                idx = (s * BPS + j) * SIZE;
                blk = cs_block(src_a[idx +: SIZE], src_bx[idx +: SIZE], carry);
                src_sum[idx +: SIZE] = blk[SIZE-1:0];
                carry = blk[SIZE];
            end
            if (load_s[s]) begin
                valid_s[s] = in_v;
                if (in_v) begin
                    a_s[s]     = src_a;
                    bx_s[s]    = src_bx;
                    sum_s[s]   = src_sum;
                    carry_s[s] = carry;
                    if (s == STAGES - 1) begin
                        // a ^ bx ^ sum at the MSB recovers the carry into it.
                        ovf_s = src_a[N-1] ^ src_bx[N-1] ^ src_sum[N-1] ^ carry;
                    end else begin
                        ovf_s = ovf_s;
                    end
                end else begin
                    // Bubble moves in: keep the old data so outputs hold.
                    a_s[s]     = a_r[s];
                    bx_s[s]    = bx_r[s];
                    sum_s[s]   = sum_r[s];
                    carry_s[s] = carry_r[s];
                end
            end else begin
                valid_s[s] = valid_r[s];
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            carry_r <= '0;
            ovf_r   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_r[s]   <= '0;
                bx_r[s]  <= '0;
                sum_r[s] <= '0;
            end
        end else begin
            valid_r <= valid_s;
            carry_r <= carry_s;
            ovf_r   <= ovf_s;
            a_r     <= a_s;
            bx_r    <= bx_s;
            sum_r   <= sum_s;
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_carry_select_adder
//   Directed vectors, backpressure and mid-stream reset on the default
//   configuration (N=32, SIZE=4, BPS=2), plus randomized handshake streams on
//   two other configurations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_carry_select_adder;

    localparam int DSTAGES = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        sweep_go;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    pipelined_carry_select_adder #(.N(32), .SIZE(4), .BPS(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Randomized sweeps on two more configurations.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int GN  = (g == 0) ? 16 : 64;
        localparam int GS  = (g == 0) ? 4 : 8;
        localparam int GB  = (g == 0) ? 4 : 1;
        localparam int GST = GN / GS / GB;
        localparam int EXACT_CYC = 200;
        localparam int RUN_CYC   = 10000;

        logic          s_in_valid;
        logic          s_in_ready;
        logic [GN-1:0] s_a;
        logic [GN-1:0] s_b;
        logic          s_cin;
        logic          s_sub;
        logic          s_out_valid;
        logic          s_out_ready;
        logic [GN-1:0] s_sum;
        logic          s_cout;
        logic          s_ovf;
        logic          done;

        pipelined_carry_select_adder #(.N(GN), .SIZE(GS), .BPS(GB)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .sub       (s_sub),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum       (s_sum),
            .cout      (s_cout),
            .ovf       (s_ovf)
        );

        initial begin : drive
            logic [GN:0]   exp_q[$];
            logic          eovf_q[$];
            int            acc_q[$];
            logic [63:0]   r1;
            logic [63:0]   r2;
            logic [GN-1:0] bxv;
            logic [GN:0]   full;
            logic [GN:0]   e;
            logic          eo;
            logic          rov;
            logic          prev_stall;
            logic [GN-1:0] prev_sum;
            logic          prev_cout;
            logic          prev_ovf;
            int            pick;
            int            acc;
            int            drain;
            done        = 1'b0;
            s_in_valid  = 1'b0;
            s_out_ready = 1'b0;
            s_a         = '0;
            s_b         = '0;
            s_cin       = 1'b0;
            s_sub       = 1'b0;
            prev_stall  = 1'b0;
            prev_sum    = '0;
            prev_cout   = 1'b0;
            prev_ovf    = 1'b0;
            wait (sweep_go);
            for (int cyc = 0; cyc < RUN_CYC + 60; cyc++) begin
                @(negedge clk);
                if (prev_stall) begin
                    chk("sweep_hold_valid", s_out_valid, 1);
                    chk("sweep_hold_data", {s_sum, s_cout, s_ovf}, {prev_sum, prev_cout, prev_ovf});
                end
                if (cyc < RUN_CYC) begin
                    r1   = {$urandom, $urandom};
                    r2   = {$urandom, $urandom};
                    pick = $urandom_range(0, 7);
                    s_a  = (pick == 0) ? '1 : (pick == 3) ? {1'b0, {(GN-1){1'b1}}} : r1[GN-1:0];
                    s_b  = (pick == 1) ? '1 : (pick == 2) ? {{(GN-1){1'b0}}, 1'b1} : r2[GN-1:0];
                    s_cin = 1'($urandom_range(0, 1));
                    s_sub = 1'($urandom_range(0, 1));
                    s_in_valid  = 1'($urandom_range(0, 1));
                    s_out_ready = (cyc < EXACT_CYC) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end else begin
                    s_in_valid  = 1'b0;
                    s_out_ready = 1'b1;
                end
                #1;
                if (s_out_valid && s_out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sweep_spurious: out_valid with nothing in flight, got %0h", s_sum);
                    end else begin
                        e   = exp_q.pop_front();
                        eo  = eovf_q.pop_front();
                        acc = acc_q.pop_front();
                        chk("sweep_sum", 64'(s_sum), 64'(e[GN-1:0]));
                        chk("sweep_cout_ovf", {s_cout, s_ovf}, {e[GN], eo});
                        if (acc + GST < EXACT_CYC) begin
                            chk("sweep_latency", cyc - acc, GST);
                        end else begin
                            chk("sweep_latency_min", (cyc - acc) >= GST, 1);
                        end
                    end
                end
                if (s_in_valid && s_in_ready) begin
                    bxv  = s_sub ? ~s_b : s_b;
                    full = {1'b0, s_a} + {1'b0, bxv} + {{GN{1'b0}}, (s_sub | s_cin)};
                    // Overflow: both addends share a sign the result does not.
                    rov  = (s_a[GN-1] == bxv[GN-1]) && (full[GN-1] != s_a[GN-1]);
                    exp_q.push_back(full);
                    eovf_q.push_back(rov);
                    acc_q.push_back(cyc);
                end
                prev_stall = s_out_valid && !s_out_ready;
                prev_sum   = s_sum;
                prev_cout  = s_cout;
                prev_ovf   = s_ovf;
            end
            drain = exp_q.size();
            chk("sweep_drained", drain, 0);
            done = 1'b1;
        end
    end

    initial begin
        vec_t tbl[8];
        int   lat;
        int   idx_in;
        int   idx_out;
        int   t;
        logic seen;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[3] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        tbl[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[6] = '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

        vectors     = 0;
        miscompares = 0;
        sweep_go    = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single transactions from the table, unstalled
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("tbl_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("tbl_latency", lat, DSTAGES);
            chk("tbl_sum", sum, tbl[i].s);
            chk("tbl_cout", cout, tbl[i].co);
            chk("tbl_ovf", ovf, tbl[i].ov);
        end

        // Backpressure: a=i, b=3i, consumer stalls from cycle 2 to 11
        @(negedge clk);
        idx_in = 0;
        idx_out = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            in_valid  = (idx_in < 10);
            a         = idx_in;
            b         = 3 * idx_in;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = (cyc < 2) || (cyc >= 12);
            #1;
            if (cyc == 11) begin
                chk("bp_accepts", idx_in, DSTAGES);
                chk("bp_in_ready_low", in_ready, 0);
            end
            if (cyc >= 5 && cyc < 12) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_sum", sum, 0);
            end
            if (cyc >= 12 && idx_out < 10) chk("bp_no_gap", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("bp_sum", sum, 4 * idx_out);
                chk("bp_cout_ovf", {cout, ovf}, 2'b00);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
        end
        chk("bp_all_out", idx_out, 10);

        // Mid-stream reset: three accepts, then a one-cycle reset pulse
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 100 + i; b = 7; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("mr_in_ready", in_ready, 1);
            seen = seen | out_valid;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            seen = seen | out_valid;
            @(negedge clk);
        end
        chk("mr_no_output", seen, 0);
        chk("mr_in_ready_after", in_ready, 1);

        // Randomized sweeps on the other configurations
        sweep_go = 1'b1;
        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!(g_sweep[0].done && g_sweep[1].done)) begin
            vectors++;
            miscompares++;
            $display("FAIL sweep_timeout: sweeps not finished after %0d cycles", t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
